// File: rtl/lag_sequencer.sv
// lag_sequencer: runs display-lag trials (frame-synced white flash, clock count until the photo-sensor sees light).
// Optional min/max/sum/count statistics are built when LAG_SEQ_STATS_EN is defined; otherwise they read as 0.
module lag_sequencer #(
    parameter int               CNT_W      = 24,
    parameter int               GAP_FRAMES = 4,
    parameter logic [CNT_W-1:0] TIMEOUT    = 24'd5_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vblank,
    input  logic             sensor,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       trials,
    output logic             flash,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_cycles,
    output logic             result_timeout,
    output logic             done,
    output logic [CNT_W-1:0] min_cycles,
    output logic [CNT_W-1:0] max_cycles,
    output logic [CNT_W+7:0] sum_cycles,
    output logic [7:0]       ok_count
);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT_AV, S_MEASURE, S_GAP} state_t;

    localparam logic [7:0] GAP_N = 8'(GAP_FRAMES);

    logic r_sensor_m, r_sensor_s, r_vb_d;
    logic w_vb_rise, w_vb_fall;

    // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sensor_m <= 1'b0;
            r_sensor_s <= 1'b0;
            r_vb_d     <= 1'b0;
        end else begin
            r_sensor_m <= sensor;
            r_sensor_s <= r_sensor_m;
            r_vb_d     <= vblank;
        end
    end

    assign w_vb_rise = vblank & ~r_vb_d;
    assign w_vb_fall = ~vblank & r_vb_d;

    state_t           r_state;
    logic [7:0]       r_left;
    logic [7:0]       r_gap_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flash, r_busy, r_result_valid, r_result_timeout, r_done;
    logic [CNT_W-1:0] r_result_cycles;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_left           <= 8'd0;
            r_gap_cnt        <= 8'd0;
            r_cnt            <= '0;
            r_flash          <= 1'b0;
            r_busy           <= 1'b0;
            r_result_valid   <= 1'b0;
            r_result_timeout <= 1'b0;
            r_result_cycles  <= '0;
            r_done           <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_done         <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_flash <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (trials != 8'd0) begin
                                r_left  <= trials;
                                r_busy  <= 1'b1;
                                r_state <= S_ARM;
                            end else begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (w_vb_rise) begin
                            r_flash <= 1'b1;
                            r_state <= S_WAIT_AV;
                        end
                    end
                    S_WAIT_AV: begin
                        if (w_vb_fall) begin
                            r_cnt   <= '0;
                            r_state <= S_MEASURE;
                        end
                    end
                    S_MEASURE: begin
                        // Sensor is tested first so a simultaneous timeout loses; cnt stops at TIMEOUT.
                        if (r_sensor_s) begin
                            r_result_cycles  <= r_cnt;
                            r_result_timeout <= 1'b0;
                            r_result_valid   <= 1'b1;
                            r_flash          <= 1'b0;
                            r_gap_cnt        <= 8'd0;
                            r_state          <= S_GAP;
                        end else if (r_cnt == TIMEOUT) begin
                            r_result_cycles  <= TIMEOUT;
                            r_result_timeout <= 1'b1;
                            r_result_valid   <= 1'b1;
                            r_flash          <= 1'b0;
                            r_gap_cnt        <= 8'd0;
                            r_state          <= S_GAP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        if (w_vb_rise && r_gap_cnt != 8'hFF) begin
                            r_gap_cnt <= r_gap_cnt + 8'd1;
                        end
                        if (r_gap_cnt >= GAP_N && !r_sensor_s) begin
                            if (r_left != 8'd1) begin
                                r_left  <= r_left - 8'd1;
                                r_state <= S_ARM;
                            end else begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_flash <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign flash          = r_flash;
    assign busy           = r_busy;
    assign result_valid   = r_result_valid;
    assign result_cycles  = r_result_cycles;
    assign result_timeout = r_result_timeout;
    assign done           = r_done;

`ifdef LAG_SEQ_STATS_EN
    logic             w_start_ok, w_ok_result;
    logic [CNT_W-1:0] r_min, r_max;
    logic [CNT_W+7:0] r_sum;
    logic [7:0]       r_ok;

    // Mirrors the FSM's accept and sensor-hit conditions so stats move on the result_valid edge.
    assign w_start_ok  = (r_state == S_IDLE) && start && !abort;
    assign w_ok_result = (r_state == S_MEASURE) && r_sensor_s && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_ok  <= 8'd0;
        end else if (w_start_ok) begin
            r_min <= '1;
            r_max <= '0;
            r_sum <= '0;
            r_ok  <= 8'd0;
        end else if (w_ok_result) begin
            if (r_cnt < r_min) r_min <= r_cnt;
            if (r_cnt > r_max) r_max <= r_cnt;
            r_sum <= r_sum + {8'd0, r_cnt};
            if (r_ok != 8'hFF) r_ok <= r_ok + 8'd1;
        end
    end

    assign min_cycles = r_min;
    assign max_cycles = r_max;
    assign sum_cycles = r_sum;
    assign ok_count   = r_ok;
`else
    assign min_cycles = '0;
    assign max_cycles = '0;
    assign sum_cycles = '0;
    assign ok_count   = 8'd0;
`endif

endmodule

// File: tb/tb_lag_sequencer.sv
// Scoreboard bench for lag_sequencer: stimulus pushes expected results/run summaries, a monitor pops and compares.
// Statistics expectations follow LAG_SEQ_STATS_EN (zeros when it is not defined).
module tb_lag_sequencer;

    localparam int          FRAME   = 400;
    localparam int          VB_LEN  = 40;
    localparam int          TMO     = 1200;
    localparam logic [23:0] ONES    = 24'hFF_FFFF;
`ifdef LAG_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic [23:0] cycles;
        logic        timeout;
    } res_t;

    typedef struct {
        logic [23:0] mn;
        logic [23:0] mx;
        logic [31:0] sum;
        logic [7:0]  ok;
    } stat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vblank = 1'b0;
    logic        sensor = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  trials = 8'd0;
    logic        flash, busy, result_valid, result_timeout, done;
    logic [23:0] result_cycles, min_cycles, max_cycles;
    logic [31:0] sum_cycles;
    logic [7:0]  ok_count;

    int   pos = 100;
    int   n_cmp = 0;
    int   n_err = 0;
    res_t  exp_res[$];
    stat_t exp_done[$];

    lag_sequencer #(.CNT_W(24), .GAP_FRAMES(4), .TIMEOUT(24'd1200)) dut (
        .clk(clk), .reset_n(reset_n), .vblank(vblank), .sensor(sensor),
        .start(start), .abort(abort), .trials(trials),
        .flash(flash), .busy(busy), .result_valid(result_valid),
        .result_cycles(result_cycles), .result_timeout(result_timeout), .done(done),
        .min_cycles(min_cycles), .max_cycles(max_cycles),
        .sum_cycles(sum_cycles), .ok_count(ok_count)
    );

    always #5 clk = ~clk;

    // Frame timing: vblank high for the first VB_LEN cycles of every FRAME.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pos    = (pos + 1) % FRAME;
            vblank = (pos < VB_LEN);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stat_t mk_stat(input logic [23:0] mn, input logic [23:0] mx,
                                      input logic [31:0] sum, input logic [7:0] ok);
        stat_t s;
        s.mn  = STATS ? mn  : 24'd0;
        s.mx  = STATS ? mx  : 24'd0;
        s.sum = STATS ? sum : 32'd0;
        s.ok  = STATS ? ok  : 8'd0;
        return s;
    endfunction

    // Monitor: every result/done pulse must match the head of its expectation queue.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (result_valid) begin
                    if (exp_res.size() == 0) begin
                        check("unexpected_result", result_valid, 0);
                    end else begin
                        res_t e;
                        e = exp_res.pop_front();
                        check("result_cycles", result_cycles, e.cycles);
                        check("result_timeout", result_timeout, e.timeout);
                    end
                    if (done) check("valid_done_overlap", done, 0);
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", done, 0);
                    end else begin
                        stat_t s;
                        s = exp_done.pop_front();
                        check("min_cycles", min_cycles, s.mn);
                        check("max_cycles", max_cycles, s.mx);
                        check("sum_cycles", sum_cycles, s.sum);
                        check("ok_count", ok_count, s.ok);
                    end
                end
            end
        end
    end

    // which: 0 flash high, 1 vblank low, 2 result_valid, 3 done
    task automatic wait_cond(input int which, input int budget, input string name);
        logic met = 1'b0;
        for (int i = 0; i < budget && !met; i++) begin
            @(negedge clk);
            case (which)
                0:       met = flash;
                1:       met = ~vblank;
                2:       met = result_valid;
                default: met = done;
            endcase
        end
        check(name, met, 1);
    endtask

    task automatic pulse_start(input logic [7:0] n);
        @(posedge clk);
        #1;
        trials = n;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (n != 8'd0) begin
            @(negedge clk);
            check("busy_after_start", busy, 1);
        end
    endtask

    // d < 0: sensor never lights (timeout trial). hold: cycles sensor stays lit after the result.
    task automatic do_trial(input int d, input int hold);
        res_t e;
        e.cycles  = (d < 0) ? 24'(TMO) : 24'(d + 1);
        e.timeout = (d < 0);
        exp_res.push_back(e);
        wait_cond(0, 3000, "wait_flash");
        check("flash_phase", pos, 1);
        wait_cond(1, 500, "wait_active");
        if (d >= 0) begin
            repeat (d) @(posedge clk);
            #1 sensor = 1'b1;
        end
        wait_cond(2, 1500, "wait_result");
        if (d >= 0) begin
            if (hold > 2000) begin
                repeat (2000) @(posedge clk);
                @(negedge clk);
                check("stuck_gap_busy", busy, 1);
                check("stuck_gap_flash", flash, 0);
                repeat (hold - 2000) @(posedge clk);
            end else begin
                repeat (hold) @(posedge clk);
            end
            #1 sensor = 1'b0;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_flash"}, flash, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_result_valid"}, result_valid, 0);
        check({tag, "_result_timeout"}, result_timeout, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result_cycles"}, result_cycles, 0);
        check({tag, "_min"}, min_cycles, STATS ? ONES : 24'd0);
        check({tag, "_max"}, max_cycles, 0);
        check({tag, "_sum"}, sum_cycles, 0);
        check({tag, "_ok"}, ok_count, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got time %0t, expected finish earlier", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic seen_flash = 1'b0;
        logic seen_busy  = 1'b0;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("init");

        // Single trial, 1000-cycle sensor delay.
        pulse_start(8'd1);
        do_trial(1000, 20);
        exp_done.push_back(mk_stat(24'd1001, 24'd1001, 32'd1001, 8'd1));
        wait_cond(3, 3000, "wait_done_a");

        // Three trials.
        pulse_start(8'd3);
        do_trial(500, 20);
        do_trial(700, 20);
        do_trial(600, 20);
        exp_done.push_back(mk_stat(24'd501, 24'd701, 32'd1803, 8'd3));
        wait_cond(3, 3000, "wait_done_b");

        // Timeout trial: stats stay at their start-of-run values.
        pulse_start(8'd1);
        do_trial(-1, 0);
        exp_done.push_back(mk_stat(ONES, 24'd0, 32'd0, 8'd0));
        wait_cond(3, 3000, "wait_done_c");

        // trials = 0: one done pulse, no flash, never busy.
        exp_done.push_back(mk_stat(ONES, 24'd0, 32'd0, 8'd0));
        pulse_start(8'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_flash |= flash;
            seen_busy  |= busy;
        end
        check("zero_trials_flash", seen_flash, 0);
        check("zero_trials_busy", seen_busy, 0);

        // Sensor held through GAP, then a second trial.
        pulse_start(8'd2);
        do_trial(300, 2400);
        do_trial(100, 20);
        exp_done.push_back(mk_stat(24'd101, 24'd301, 32'd402, 8'd2));
        wait_cond(3, 3000, "wait_done_d");

        // Abort during WAIT_AV.
        pulse_start(8'd1);
        wait_cond(0, 3000, "abort_wait_flash");
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_flash", flash, 0);
        repeat (900) @(negedge clk);

        // Reset mid-MEASURE: outputs clear without a clock edge.
        pulse_start(8'd1);
        wait_cond(0, 3000, "reset_wait_flash");
        wait_cond(1, 500, "reset_wait_active");
        repeat (50) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check_reset_vals("post_reset");

        repeat (5) @(negedge clk);
        check("exp_res_drained", exp_res.size(), 0);
        check("exp_done_drained", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
